fetch_stimulator: RTL and testbench

FETCH_STIMULATOR -- requirements
Module: fetch_stimulator

---
 rtl/stim_pkg.sv | 20 ++
 rtl/trace_fifo.sv | 56 +++++
 rtl/fetch_stimulator.sv | 119 +++++++++++
 tb/tb_fetch_stimulator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared types for the fetch stimulator: FSM state encoding and trace FIFO entry.
package stim_pkg;

  // Trace entries carry the widest supported PC; narrower XLEN values are zero-extended.
  localparam int XLEN_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } stim_state_t;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         inst;
    logic                comp;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Registered synchronous FIFO of trace entries; head is read straight from storage.
module trace_fifo
  import stim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  trace_entry_t             din,
  output trace_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  // Storage is cleared on reset so the head fields read as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/fetch_stimulator.sv
// Fetch-side stimulus generator: offers PCs, retires instructions, and logs them to a trace FIFO.
//
// state    | meaning
// ST_IDLE  | one cycle after reset, no fetch request
// ST_RUN   | offering pc, accepting instructions
// ST_STALL | trace FIFO full, waiting for the consumer to pop
// ST_DONE  | retire limit reached, terminal until reset
module fetch_stimulator
  import stim_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              TRACE_DEPTH = 4,
  parameter int unsigned     MAX_INSTS   = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic            req_valid,
  input  logic            inst_valid,
  input  logic            inst_comp,
  input  logic [31:0]     inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [31:0]     trace_inst,
  output logic            trace_comp,
  output logic [31:0]     retired,
  output logic            done
);

  localparam int          CW       = $clog2(TRACE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TRACE_DEPTH);
  localparam logic [31:0] MAX_C    = MAX_INSTS;

  stim_state_t  state, state_next;
  logic [XLEN-1:0] pc_q;
  logic [31:0]  retired_q;
  logic [31:0]  retired_inc;
  logic         accept;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  trace_entry_t push_entry;
  trace_entry_t head;

  assign req_valid   = (state == ST_RUN);
  assign done        = (state == ST_DONE);
  assign accept      = req_valid & inst_valid & ~redirect_valid;
  assign pop         = trace_valid & trace_ready;
  assign count_next  = fifo_count + CW'(accept) - CW'(pop);
  assign retired_inc = (retired_q == 32'hFFFF_FFFF) ? retired_q : retired_q + 32'd1;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_RUN;
      ST_RUN: begin
        if (accept && (MAX_C != '0) && (retired_inc == MAX_C)) begin
          state_next = ST_DONE;
        end else if (count_next == DEPTH_C) begin
          state_next = ST_STALL;
        end
      end
      ST_STALL: begin
        if (count_next < DEPTH_C) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // An accept and a redirect never coincide; a redirect in DONE is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        pc_q      <= pc_q + (inst_comp ? XLEN'(2) : XLEN'(4));
        retired_q <= retired_inc;
      end else if (redirect_valid && (state != ST_DONE)) begin
        pc_q <= {redirect_pc[XLEN-1:1], 1'b0};
      end
    end
  end

  assign push_entry = '{pc: XLEN_MAX'(pc_q), inst: inst, comp: inst_comp};

  trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pc          = pc_q;
  assign retired     = retired_q;
  assign trace_valid = ~fifo_empty;
  assign trace_pc    = head.pc[XLEN-1:0];
  assign trace_inst  = head.inst;
  assign trace_comp  = head.comp;

endmodule

// File: tb/tb_fetch_stimulator.sv
// Bench for fetch_stimulator: two configurations driven together, checked against a queue-based model.
module tb_fetch_stimulator;

  localparam int DEPTH = 4;
  localparam logic [63:0] RPC_B = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        comp;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic        inst_comp = 1'b0;
  logic [31:0] inst = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        trace_ready = 1'b0;

  logic [63:0] pc_a, pc_b, trace_pc_a, trace_pc_b;
  logic        req_a, req_b, tv_a, tv_b, tc_a, tc_b, done_a, done_b;
  logic [31:0] ti_a, ti_b, ret_a, ret_b;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_pc   [2];
  logic [31:0] m_ret  [2];
  bit          m_req  [2];
  bit          m_done [2];
  ent_t        mq     [2][$];
  logic [63:0] m_rpc  [2] = '{64'd0, RPC_B};
  int unsigned m_max  [2] = '{0, 3};

  always #5 clk = ~clk;

  fetch_stimulator #(.XLEN(64), .RESET_PC(64'd0), .TRACE_DEPTH(DEPTH), .MAX_INSTS(0)) dut_a (
    .clk(clk), .rst(rst), .pc(pc_a), .req_valid(req_a), .inst_valid(inst_valid),
    .inst_comp(inst_comp), .inst(inst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trace_valid(tv_a), .trace_ready(trace_ready), .trace_pc(trace_pc_a), .trace_inst(ti_a),
    .trace_comp(tc_a), .retired(ret_a), .done(done_a));

  fetch_stimulator #(.XLEN(64), .RESET_PC(RPC_B), .TRACE_DEPTH(DEPTH), .MAX_INSTS(3)) dut_b (
    .clk(clk), .rst(rst), .pc(pc_b), .req_valid(req_b), .inst_valid(inst_valid),
    .inst_comp(inst_comp), .inst(inst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trace_valid(tv_b), .trace_ready(trace_ready), .trace_pc(trace_pc_b), .trace_inst(ti_b),
    .trace_comp(tc_b), .retired(ret_b), .done(done_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: one call per rising edge, using the inputs present at that edge.
  task automatic model_step();
    bit acc, pop;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pc[i] = m_rpc[i];
        m_ret[i] = '0;
        m_req[i] = 0;
        m_done[i] = 0;
        mq[i].delete();
      end else begin
        acc = m_req[i] && inst_valid && !redirect_valid;
        pop = (mq[i].size() > 0) && trace_ready;
        if (pop) void'(mq[i].pop_front());
        if (acc) begin
          mq[i].push_back('{m_pc[i], inst, inst_comp});
          m_pc[i] = m_pc[i] + (inst_comp ? 64'd2 : 64'd4);
          if (m_ret[i] != 32'hFFFF_FFFF) m_ret[i] = m_ret[i] + 32'd1;
          if (m_max[i] != 0 && m_ret[i] == m_max[i]) m_done[i] = 1;
        end else if (redirect_valid && !m_done[i]) begin
          m_pc[i] = redirect_pc & ~64'd1;
        end
        m_req[i] = !m_done[i] && (mq[i].size() < DEPTH);
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] o_pc, o_tpc;
    logic [31:0] o_ret, o_ti;
    logic        o_req, o_tv, o_tc, o_done;
    for (int i = 0; i < 2; i++) begin
      o_pc   = (i == 0) ? pc_a : pc_b;
      o_req  = (i == 0) ? req_a : req_b;
      o_ret  = (i == 0) ? ret_a : ret_b;
      o_done = (i == 0) ? done_a : done_b;
      o_tv   = (i == 0) ? tv_a : tv_b;
      o_tpc  = (i == 0) ? trace_pc_a : trace_pc_b;
      o_ti   = (i == 0) ? ti_a : ti_b;
      o_tc   = (i == 0) ? tc_a : tc_b;
      chk($sformatf("pc[%0d]", i), o_pc, m_pc[i]);
      chk($sformatf("req_valid[%0d]", i), 64'(o_req), 64'(m_req[i]));
      chk($sformatf("retired[%0d]", i), 64'(o_ret), 64'(m_ret[i]));
      chk($sformatf("done[%0d]", i), 64'(o_done), 64'(m_done[i]));
      chk($sformatf("trace_valid[%0d]", i), 64'(o_tv), 64'(mq[i].size() > 0));
      if (mq[i].size() > 0) begin
        chk($sformatf("trace_pc[%0d]", i), o_tpc, mq[i][0].pc);
        chk($sformatf("trace_inst[%0d]", i), 64'(o_ti), 64'(mq[i][0].inst));
        chk($sformatf("trace_comp[%0d]", i), 64'(o_tc), 64'(mq[i][0].comp));
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    chk("rst_trace_pc", trace_pc_a, 64'd0);
    chk("rst_trace_inst", 64'(ti_a), 64'd0);
    chk("rst_trace_comp", 64'(tc_a), 64'd0);
    chk("rst_pc_b", pc_b, RPC_B);
    chk("rst_req", 64'(req_a), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_to_run", 64'(req_a), 64'd1);

    // Four accepts with alternating compressed flag
    trace_ready = 1'b1;
    inst_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      inst_comp = k[0];
      inst = $urandom;
      tick();
      if (k == 0) begin
        chk("wrap_pc_b", pc_b, 64'd0);
        chk("first_trace_pc", trace_pc_a, 64'd0);
      end
    end
    chk("seq_pc", pc_a, 64'd12);
    chk("seq_retired", 64'(ret_a), 64'd4);
    chk("limit_done", 64'(done_b), 64'd1);
    chk("limit_req", 64'(req_b), 64'd0);
    chk("limit_retired", 64'(ret_b), 64'd3);
    chk("limit_pc", pc_b, 64'd6);

    inst_valid = 1'b0;
    tick();
    tick();

    // Redirect concurrent with an instruction
    redirect_valid = 1'b1;
    redirect_pc = 64'h1001;
    inst_valid = 1'b1;
    tick();
    chk("redir_pc", pc_a, 64'h1000);
    chk("redir_retired", 64'(ret_a), 64'd4);
    chk("redir_no_trace", 64'(tv_a), 64'd0);
    chk("done_ignores_redir", pc_b, 64'd6);
    redirect_valid = 1'b0;

    // Fill the FIFO with the consumer blocked
    trace_ready = 1'b0;
    inst_comp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inst = $urandom;
      tick();
    end
    chk("full_stall", 64'(req_a), 64'd0);
    tick();
    chk("stall_hold", 64'(req_a), 64'd0);
    chk("stall_pc", pc_a, 64'h1010);
    inst_valid = 1'b0;
    trace_ready = 1'b1;
    tick();
    chk("resume_after_pop", 64'(req_a), 64'd1);
    for (int k = 0; k < 4; k++) tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      inst_valid = ($urandom_range(0, 3) != 0);
      inst_comp = $urandom_range(0, 1);
      inst = $urandom;
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = {$urandom, $urandom};
      trace_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Reset with entries queued
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    trace_ready = 1'b0;
    inst_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inst = $urandom;
      tick();
    end
    chk("three_queued", 64'(tv_a), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_flush_tv", 64'(tv_a), 64'd0);
    chk("rst_flush_ret", 64'(ret_a), 64'd0);
    chk("rst_flush_pc", pc_a, 64'd0);
    chk("rst_flush_pc_b", pc_b, RPC_B);
    rst = 1'b0;
    inst_valid = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
